// File: rtl/output_store_pkg.sv
// Shared types and helpers for the output line packer: FSM state encoding,
// a constant-capable clog2 and the lane mask generator used for partial lines.
package output_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // Upper bound on ELEMS supported by the mask helper.
    localparam int MAX_ELEMS = 64;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // lane_cnt must be able to hold the value ELEMS itself.
    function automatic int lane_cnt_width(input int elems);
        return clog2(elems + 1);
    endfunction

    // Low-n ones; with msb_first the run is mirrored to the top n lanes of elems.
    function automatic logic [MAX_ELEMS-1:0] mask_from_count(input int n, input int elems,
                                                             input bit msb_first);
        logic [MAX_ELEMS-1:0] mask;
        int                   fill;
        fill = (n < 0) ? 0 : ((n > elems) ? elems : n);
        mask = (MAX_ELEMS'(1) << fill) - MAX_ELEMS'(1);
        if (msb_first) begin
            mask = mask << (elems - fill);
        end
        return mask;
    endfunction

endpackage

// File: rtl/output_lane_insert.sv
// Combinational lane writer: places one element into the pack register at the
// lane selected by the fill index and the configured fill order.
module output_lane_insert
    import output_store_pkg::*;
#(
    parameter int ELEM_W    = 8,
    parameter int ELEMS     = 16,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = lane_cnt_width(ELEMS)
) (
    input  logic [ELEM_W*ELEMS-1:0] pack_in,
    input  logic [CNT_W-1:0]        lane_idx,
    input  logic [ELEM_W-1:0]       elem,
    output logic [ELEM_W*ELEMS-1:0] pack_out
);

    logic [CNT_W-1:0] lane;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        lane     = (MSB_FIRST != 0) ? CNT_W'(ELEMS - 1) - lane_idx : lane_idx;
        pack_out = pack_in;
        for (int i = 0; i < ELEMS; i++) begin
            if (lane == CNT_W'(i)) begin
                pack_out[i*ELEM_W +: ELEM_W] = elem;
            end
        end
    end

endmodule

// File: rtl/output_line_packer.sv
// Packs a valid/ready element stream into ELEMS-lane lines and writes each line,
// plus a masked partial line at frame end, through a single holding register.
module output_line_packer
    import output_store_pkg::*;
#(
    parameter int ELEM_W    = 8,
    parameter int ELEMS     = 16,
    parameter int ADDR_W    = 16,
    parameter int MSB_FIRST = 1,
    localparam int LINE_W   = ELEM_W * ELEMS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              result_valid,
    input  logic [ELEM_W-1:0] result_in,
    output logic              result_ready,
    output logic [LINE_W-1:0] write_bus,
    output logic [ADDR_W-1:0] write_address,
    output logic [ELEMS-1:0]  write_mask,
    output logic              write_enable,
    input  logic              write_ready,
    output logic              frame_done,
    output logic [ADDR_W-1:0] line_count
);

    localparam int CNT_W = lane_cnt_width(ELEMS);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] addr_ptr_q,   addr_ptr_d;
    logic [CNT_W-1:0]  lane_cnt_q,   lane_cnt_d;
    logic [LINE_W-1:0] pack_q,       pack_d;
    logic [LINE_W-1:0] wr_bus_q,     wr_bus_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [ELEMS-1:0]  wr_mask_q,    wr_mask_d;
    logic              wr_en_q,      wr_en_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] line_cnt_q,   line_cnt_d;

    logic [LINE_W-1:0] pack_ins;
    logic              hold_free;
    logic              lane_last;
    logic              accept;

    output_lane_insert #(
        .ELEM_W    (ELEM_W),
        .ELEMS     (ELEMS),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_lane_insert (
        .pack_in  (pack_q),
        .lane_idx (lane_cnt_q),
        .elem     (result_in),
        .pack_out (pack_ins)
    );

    always_comb begin
        state_d      = state_q;
        addr_ptr_d   = addr_ptr_q;
        lane_cnt_d   = lane_cnt_q;
        pack_d       = pack_q;
        wr_bus_d     = wr_bus_q;
        wr_addr_d    = wr_addr_q;
        wr_mask_d    = wr_mask_q;
        wr_en_d      = wr_en_q;
        frame_done_d = 1'b0;
        line_cnt_d   = line_cnt_q;

        // The holding register can take a new line in the same cycle it drains.
        hold_free = !wr_en_q || write_ready;
        if (wr_en_q && write_ready) begin
            wr_en_d = 1'b0;
        end

        // Only the line-completing element needs a free holding register.
        lane_last    = (lane_cnt_q == CNT_W'(ELEMS - 1));
        result_ready = (state_q == ST_FILL) && start_in && !(lane_last && wr_en_q && !write_ready);
        accept       = result_valid && result_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d    = ST_FILL;
                    addr_ptr_d = base_addr;
                    lane_cnt_d = '0;
                    line_cnt_d = '0;
                    pack_d     = '0;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (lane_last) begin
                        wr_bus_d   = pack_ins;
                        wr_mask_d  = '1;
                        wr_addr_d  = addr_ptr_q;
                        wr_en_d    = 1'b1;
                        addr_ptr_d = addr_ptr_q + ADDR_W'(1);
                        line_cnt_d = line_cnt_q + ADDR_W'(1);
                        lane_cnt_d = '0;
                        pack_d     = '0;
                    end else begin
                        pack_d     = pack_ins;
                        lane_cnt_d = lane_cnt_q + CNT_W'(1);
                    end
                end
                if (!start_in) begin
                    state_d = (lane_cnt_q != '0) ? ST_FLUSH : ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (hold_free) begin
                    wr_bus_d   = pack_q;
                    wr_mask_d  = ELEMS'(mask_from_count(int'(lane_cnt_q), ELEMS, MSB_FIRST != 0));
                    wr_addr_d  = addr_ptr_q;
                    wr_en_d    = 1'b1;
                    addr_ptr_d = addr_ptr_q + ADDR_W'(1);
                    line_cnt_d = line_cnt_q + ADDR_W'(1);
                    lane_cnt_d = '0;
                    pack_d     = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (hold_free) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_ptr_q   <= '0;
            lane_cnt_q   <= '0;
            pack_q       <= '0;
            wr_bus_q     <= '0;
            wr_addr_q    <= '0;
            wr_mask_q    <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            line_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_ptr_q   <= addr_ptr_d;
            lane_cnt_q   <= lane_cnt_d;
            pack_q       <= pack_d;
            wr_bus_q     <= wr_bus_d;
            wr_addr_q    <= wr_addr_d;
            wr_mask_q    <= wr_mask_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            line_cnt_q   <= line_cnt_d;
        end
    end

    assign write_bus     = wr_bus_q;
    assign write_address = wr_addr_q;
    assign write_mask    = wr_mask_q;
    assign write_enable  = wr_en_q;
    assign frame_done    = frame_done_q;
    assign line_count    = line_cnt_q;

endmodule
